// File: rtl/audio_pkg.sv
// Shared definitions for the audio output path.
// Contents:
//   NUM_NOTES     - width of the one-hot note bus (C4..B4)
//   NOTE_C4..B4   - note index constants, bit position in the one-hot bus
//   STEP_LUT      - phase increments for a 24-bit accumulator sampled at
//                   100 MHz / 256, round(f * 2^24 / 390625)
//   wave_e        - waveform selector; the unused code 3 plays a square
package audio_pkg;

  localparam int NUM_NOTES = 7;
  localparam int STEP_BITS = 24;

  localparam logic [2:0] NOTE_C4 = 3'd0;
  localparam logic [2:0] NOTE_D4 = 3'd1;
  localparam logic [2:0] NOTE_E4 = 3'd2;
  localparam logic [2:0] NOTE_F4 = 3'd3;
  localparam logic [2:0] NOTE_G4 = 3'd4;
  localparam logic [2:0] NOTE_A4 = 3'd5;
  localparam logic [2:0] NOTE_B4 = 3'd6;

  localparam logic [STEP_BITS-1:0] STEP_LUT [NUM_NOTES] = '{
    24'd11237, 24'd12613, 24'd14157, 24'd14999,
    24'd16836, 24'd18898, 24'd21212
  };

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_TRI    = 2'd1,
    WAVE_SAW    = 2'd2
  } wave_e;

endpackage

// File: rtl/pwm_modulator.sv
// 8-bit PWM modulator for the mono audio pin.
// Ports:
//   clk_100mhz  - system clock
//   reset       - synchronous, active-high
//   duty        - compare value for the current period (0 = always low)
//   aud_pwm     - registered PWM output, lags the counter by one cycle
//   sample_tick - registered pulse, high while the counter is 0
//   boundary    - combinational strobe, high in the last cycle of a period
module pwm_modulator #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_100mhz,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] duty,
  output logic                aud_pwm,
  output logic                sample_tick,
  output logic                boundary
);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                aud_pwm_q;
  logic                sample_tick_q;

  assign boundary = (pwm_cnt_q == {PWM_BITS{1'b1}});

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      pwm_cnt_q     <= '0;
      aud_pwm_q     <= 1'b0;
      sample_tick_q <= 1'b0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_q + 1'b1;
      aud_pwm_q     <= (pwm_cnt_q < duty);
      // Registered from the last count, so the pulse coincides with count 0.
      sample_tick_q <= boundary;
    end
  end

  assign aud_pwm     = aud_pwm_q;
  assign sample_tick = sample_tick_q;

endmodule

// File: rtl/note_tone_synth.sv
// Game tone generator: one-hot note -> phase accumulator -> waveform
// shaper -> attenuator -> PWM audio output.
// Ports:
//   clk_100mhz  - system clock, 100 MHz
//   reset       - synchronous, active-high
//   enable      - 1 = play, 0 = silence and amplifier shutdown
//   note_in     - one-hot note, bit0 = C4 .. bit6 = B4 (lowest set bit wins)
//   wave_sel    - 0 square, 1 triangle, 2 sawtooth, 3 square
//   volume      - attenuation as a right shift, 0 = loudest
//   aud_pwm     - PWM audio pin
//   aud_sd      - amplifier enable, one cycle behind enable
//   sample_tick - one-cycle pulse at the start of each PWM period
//   note_idx    - index of the note playing
//   note_valid  - 1 while a note is playing
// note_in, wave_sel, volume and enable only take effect in the last cycle
// of a PWM period and govern the whole following period.
module note_tone_synth #(
  parameter int PWM_BITS  = 8,
  parameter int ACC_BITS  = 24,
  parameter int NUM_NOTES = 7
) (
  input  logic                 clk_100mhz,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_NOTES-1:0] note_in,
  input  logic [1:0]           wave_sel,
  input  logic [1:0]           volume,
  output logic                 aud_pwm,
  output logic                 aud_sd,
  output logic                 sample_tick,
  output logic [2:0]           note_idx,
  output logic                 note_valid
);
  import audio_pkg::*;

  localparam logic [PWM_BITS:0] MID = (PWM_BITS + 1)'(1) << (PWM_BITS - 1);

  logic                boundary;
  logic [ACC_BITS-1:0] phase_q, phase_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [2:0]          note_idx_q, note_idx_d;
  logic                note_valid_q, note_valid_d;
  logic                aud_sd_q;

  logic [2:0]          dec_idx;
  logic                dec_hit;
  logic                silent;
  logic [ACC_BITS-1:0] tone_phase;
  logic [PWM_BITS-1:0] p;
  logic [PWM_BITS-1:0] shape;
  logic signed [PWM_BITS:0] delta, scaled;
  logic [PWM_BITS:0]   duty_wide;

  // Priority decode: scanning downward lets the lowest set bit win.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = NOTE_C4;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (note_in[i]) begin
        dec_hit = 1'b1;
        dec_idx = 3'(i);
      end
    end
  end

  assign silent     = !enable || !dec_hit;
  assign tone_phase = silent ? '0 : phase_q + ACC_BITS'(STEP_LUT[dec_idx]);
  assign p          = tone_phase[ACC_BITS-1 -: PWM_BITS];

  always_comb begin
    case (wave_sel)
      WAVE_TRI: shape = p[PWM_BITS-1] ? ~{p[PWM_BITS-2:0], 1'b0}
                                      :  {p[PWM_BITS-2:0], 1'b0};
      WAVE_SAW: shape = p;
      default:  shape = {PWM_BITS{p[PWM_BITS-1]}};
    endcase
  end

  // Attenuate around mid-scale so quieter settings keep a 50% DC level.
  // The nine-bit sum wraps -MID back to 0, keeping duty inside 0..255.
  assign delta     = $signed({1'b0, shape} - MID);
  assign scaled    = delta >>> volume;
  assign duty_wide = $unsigned(scaled) + MID;

  always_comb begin
    phase_d      = phase_q;
    duty_d       = duty_q;
    note_idx_d   = note_idx_q;
    note_valid_d = note_valid_q;
    if (boundary) begin
      phase_d = tone_phase;
      if (silent) begin
        duty_d       = MID[PWM_BITS-1:0];
        note_valid_d = 1'b0;
      end else begin
        duty_d       = duty_wide[PWM_BITS-1:0];
        note_valid_d = 1'b1;
        note_idx_d   = dec_idx;
      end
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      phase_q      <= '0;
      duty_q       <= MID[PWM_BITS-1:0];
      note_idx_q   <= NOTE_C4;
      note_valid_q <= 1'b0;
      aud_sd_q     <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      duty_q       <= duty_d;
      note_idx_q   <= note_idx_d;
      note_valid_q <= note_valid_d;
      aud_sd_q     <= enable;
    end
  end

  pwm_modulator #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk_100mhz  (clk_100mhz),
    .reset       (reset),
    .duty        (duty_q),
    .aud_pwm     (aud_pwm),
    .sample_tick (sample_tick),
    .boundary    (boundary)
  );

  assign aud_sd     = aud_sd_q;
  assign note_idx   = note_idx_q;
  assign note_valid = note_valid_q;

endmodule
